mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequencer and arbiter that shares one single-port RAM between the instruction-fetch path and the data load/store path of the MIPS core.
- Captures requests, grants one per transaction, and drives the RAM strobes.
- Returns data and wait-release to the winning requester.
- Data accesses have priority, bounded by a fairness counter so fetch is never starved; a timeout guards against a hung RAM.

Parameters:
DSTREAK_MAX, 4, max consecutive data grants while a fetch is pending before a fetch is forced (1..15)
TIMEOUT, 16, max cycles in a serve state without ramready before the access is aborted (2..255)
BAD_WORD, 32'hBAD0BAD0, load value returned on timeout

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  reset, synchronous, active-high (asserted = 1 resets at next CLK edge)
iREN  in  1  instruction read request, held until iwait low
iaddr  in  32  instruction word address
iwait  out  1  1 = fetch not yet complete
iload  out  32  fetched word, valid when iREN & !iwait
dREN  in  1  data read request, held until dwait low
dWEN  in  1  data write request, held until dwait low
daddr  in  32  data address
dstore  in  32  write data
dwait  out  1  1 = data access not yet complete
dload  out  32  read word, valid when dREN & !dwait
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid with ramready
ramready  in  1  RAM completes current access this cycle
err  out  1  one-cycle pulse on timeout completion

Behaviour:
- States: IDLE, ISERVE, DSERVE. Reset → IDLE, streak=0, tcount=0, err=0. Captured addr/data/we regs → 0.
- Reset is synchronous; takes effect at the first CLK edge with nRST=1 and overrides every other transition, including mid-serve (access abandoned, nothing returned).
- IDLE transitions (evaluated each cycle):
  - dreq = dREN|dWEN.
  - If dreq and !(iREN and streak==DSTREAK_MAX) → DSERVE; capture daddr, dstore, we=dWEN.
  - Else if iREN → ISERVE; capture iaddr.
  - Else stay.
- dREN and dWEN both high → write.
- Streak counter:
  - On DSERVE grant with iREN high: streak+1, saturating at DSTREAK_MAX.
  - On DSERVE grant with iREN low: streak=0.
  - On ISERVE grant: streak=0.
- In ISERVE:
  - ramREN=1; ramaddr=captured addr; ramWEN=0; ramstore=0.
- In DSERVE:
  - ramaddr=captured addr; ramWEN=we; ramREN=!we; ramstore=captured data.
- IDLE: all RAM strobes 0; ramaddr/ramstore hold 0.
- tcount:
  - Clears on entry to a serve state and increments each serve cycle.
  - Timeout when tcount==TIMEOUT-1 and !ramready.
- Completion cycle (ramready, or timeout) in a serve state:
  - The served requester's wait=0 that cycle (combinational).
  - Its load = ramload, or BAD_WORD on timeout.
  - Next state IDLE. err=1 for that cycle only on timeout.
- Wait outputs:
  - iwait = iREN & !(ISERVE & completion).
  - dwait = (dREN|dWEN) & !(DSERVE & completion).
- Loads are 0 when not completing.
- Minimum latency is 2 cycles (grant edge + ready in the first serve cycle). Back-to-back accesses have one IDLE cycle between them.
- A request dropped mid-serve is a protocol violation: the access still completes on the RAM, and the result is discarded.
- Inputs changed mid-serve have no effect (captured values are used).
- ramready in IDLE is ignored.

Test Plan:
- Reset: nRST=1 for 2 cycles with iREN=1 → ramREN=0, ramWEN=0, iwait=1, err=0. State IDLE after release, first grant ISERVE.
- Single fetch: iREN=1, iaddr=0x40, ramready=1 one cycle after grant, ramload=0x2408000A → ramaddr=0x40, iload=0x2408000A with iwait=0 in cycle 2.
- Simultaneous: iREN=1, dREN=1, daddr=0x100 → DSERVE first. Fetch granted after data completes, with one IDLE cycle between.
- Starvation: iREN held, dWEN continuously re-asserted, DSTREAK_MAX=4 → exactly 4 data grants, then fetch granted, then streak=0.
- Write: dWEN=1, dREN=1, daddr=0x200, dstore=0xDEADBEEF → ramWEN=1, ramREN=0, ramstore=0xDEADBEEF until ramready.
- Timeout: iREN=1, ramready held 0, TIMEOUT=16 → iwait=0, iload=0xBAD0BAD0, err=1 on the 16th ISERVE cycle, then IDLE. Reset asserted mid-serve returns IDLE next edge with no err.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store.
// Data has priority, bounded by a streak counter; a timeout aborts hung accesses.
module mem_arbiter #(
   parameter int          DSTREAK_MAX = 4,
   parameter int          TIMEOUT     = 16,
   parameter logic [31:0] BAD_WORD    = 32'hBAD0BAD0
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  logic        ramready,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISERVE = 2'd1,
      DSERVE = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(DSTREAK_MAX);
   localparam logic [7:0] TCOUNT_LIM = 8'(TIMEOUT - 1);

   state_t      state, state_n;
   logic [3:0]  streak, streak_n;
   logic [7:0]  tcount, tcount_n;
   logic [31:0] cap_addr, cap_addr_n;
   logic [31:0] cap_data, cap_data_n;
   logic        cap_we, cap_we_n;

   logic        dreq;
   logic        serving;
   logic        timeout;
   logic        complete;

   assign dreq     = dREN | dWEN;
   assign serving  = (state == ISERVE) || (state == DSERVE);
   assign timeout  = serving && (tcount == TCOUNT_LIM) && !ramready;
   assign complete = serving && (ramready || timeout);

   always_ff @(posedge CLK) begin
      if (nRST) begin
         state    <= IDLE;
         streak   <= '0;
         tcount   <= '0;
         cap_addr <= '0;
         cap_data <= '0;
         cap_we   <= 1'b0;
      end else begin
         state    <= state_n;
         streak   <= streak_n;
         tcount   <= tcount_n;
         cap_addr <= cap_addr_n;
         cap_data <= cap_data_n;
         cap_we   <= cap_we_n;
      end
   end

   // A pending fetch wins IDLE arbitration only once data has taken DSTREAK_MAX grants in a row.
   always_comb begin
      state_n    = state;
      streak_n   = streak;
      tcount_n   = tcount;
      cap_addr_n = cap_addr;
      cap_data_n = cap_data;
      cap_we_n   = cap_we;
      unique case (state)
         IDLE: begin
            if (dreq && !(iREN && (streak == STREAK_MAX))) begin
               state_n    = DSERVE;
               cap_addr_n = daddr;
               cap_data_n = dstore;
               cap_we_n   = dWEN;
               tcount_n   = '0;
               if (!iREN)
                  streak_n = '0;
               else if (streak != STREAK_MAX)
                  streak_n = streak + 4'd1;
            end else if (iREN) begin
               state_n    = ISERVE;
               cap_addr_n = iaddr;
               cap_data_n = '0;
               cap_we_n   = 1'b0;
               tcount_n   = '0;
               streak_n   = '0;
            end
         end
         ISERVE, DSERVE: begin
            if (complete)
               state_n = IDLE;
            else
               tcount_n = tcount + 8'd1;
         end
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      iload    = '0;
      dload    = '0;
      unique case (state)
         ISERVE: begin
            ramREN  = 1'b1;
            ramaddr = cap_addr;
            if (complete)
               iload = timeout ? BAD_WORD : ramload;
         end
         DSERVE: begin
            ramREN   = !cap_we;
            ramWEN   = cap_we;
            ramaddr  = cap_addr;
            ramstore = cap_data;
            if (complete)
               dload = timeout ? BAD_WORD : ramload;
         end
         default: ;
      endcase
   end

   assign iwait = iREN & !((state == ISERVE) && complete);
   assign dwait = dreq & !((state == DSERVE) && complete);
   assign err   = timeout;

endmodule
